// File: rtl/nios2_oci_dct_sequencer.sv
// nios2_oci_dct_sequencer
//
// Sequences the OCI data-compression-trace buffer. Trace items are packed into a
// 30-bit frame buffer. Each full, flushed or end-of-test frame is drained to the
// trace sink over a valid/ready handshake.
//
// Ports:
//   clk             sole clock, rising edge
//   reset           synchronous, active-high reset
//   item_data       trace item payload (ITEM_W bits)
//   item_valid      item offered
//   item_ready      item accepted when item_valid && item_ready
//   trace_flush     single-cycle request to drain a partial frame
//   test_ending     level; request final flush and completion
//   frame_data      frame to sink, unused slots zero
//   frame_count     number of valid items in frame_data (1..SLOTS)
//   frame_valid     frame offered to sink
//   frame_ready     sink accepts when frame_valid && frame_ready
//   dct_buffer      live packing buffer (test-bench visibility)
//   dct_count       live fill count 0..SLOTS
//   test_has_ended  sticky end-of-test indication
//   dct_drop_count  items dropped while draining (only with NIOS2_OCI_DCT_OVF_CNT_EN)
//
// Optional feature macro: NIOS2_OCI_DCT_OVF_CNT_EN
//   Defined:   items are still accepted in DRAIN, dropped, and counted in a
//              saturating 16-bit counter.
//   Undefined: item_ready is low in DRAIN (backpressure); no counter.

module nios2_oci_dct_sequencer #(
   parameter int unsigned ITEM_W = 6,
   parameter int unsigned SLOTS  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ITEM_W-1:0] item_data,
   input  logic              item_valid,
   output logic              item_ready,
   input  logic              trace_flush,
   input  logic              test_ending,
   output logic [29:0]       frame_data,
   output logic [3:0]        frame_count,
   output logic              frame_valid,
   input  logic              frame_ready,
   output logic [29:0]       dct_buffer,
   output logic [3:0]        dct_count,
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
   output logic [15:0]       dct_drop_count,
`endif
   output logic              test_has_ended
);

   // Frame geometry is fixed at 30 bits.
   if (ITEM_W * SLOTS != 30) begin : g_bad_geometry
      $error("nios2_oci_dct_sequencer: ITEM_W*SLOTS must equal 30");
   end

   typedef enum logic [1:0] {StFill, StDrain, StDone} state_e;

   state_e state_q, state_d;

   logic [29:0] buffer_q;
   logic [3:0]  count_q;
   logic [29:0] frame_data_q;
   logic [3:0]  frame_count_q;

   logic        accept;
   logic [3:0]  post_count;
   logic [29:0] filled_buf;
   logic        do_drain;

   // ---------------------------------------------------------------------------
   // Packing datapath (combinational view of the buffer after this cycle's accept)
   // ---------------------------------------------------------------------------
   assign accept     = (state_q == StFill) && item_valid;
   assign post_count = count_q + {3'b000, accept};

   always_comb begin
      filled_buf = buffer_q;
      for (int unsigned i = 0; i < SLOTS; i++) begin
         if (accept && (count_q == 4'(i))) begin
            filled_buf[i*ITEM_W +: ITEM_W] = item_data;
         end
      end
   end

   // A same-cycle accept is counted before the flush/end-of-test decision.
   assign do_drain = (state_q == StFill) &&
                     ((post_count == 4'(SLOTS)) ||
                      ((trace_flush || test_ending) && (post_count != 4'd0)));

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFill;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFill: begin
            if (do_drain) begin
               state_d = StDrain;
            end else if (test_ending) begin
               // Not draining with test_ending high means the buffer is empty.
               state_d = StDone;
            end
         end
         StDrain: begin
            if (frame_ready) begin
               state_d = test_ending ? StDone : StFill;
            end
         end
         StDone:  state_d = StDone;
         default: state_d = StFill;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (registered state only, so frame_valid never depends on
   // frame_ready)
   // ---------------------------------------------------------------------------
   always_comb begin
      item_ready     = 1'b0;
      frame_valid    = 1'b0;
      test_has_ended = 1'b0;
      unique case (state_q)
         StFill:  item_ready = !reset;
         StDrain: begin
            frame_valid = 1'b1;
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
            item_ready  = !reset;
`endif
         end
         StDone:  test_has_ended = 1'b1;
         default: item_ready = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Buffer and frame registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         buffer_q      <= '0;
         count_q       <= '0;
         frame_data_q  <= '0;
         frame_count_q <= '0;
      end else if (do_drain) begin
         frame_data_q  <= filled_buf;
         frame_count_q <= post_count;
         buffer_q      <= '0;
         count_q       <= '0;
      end else if (state_q == StFill) begin
         buffer_q <= filled_buf;
         count_q  <= post_count;
      end
   end

   assign frame_data  = frame_data_q;
   assign frame_count = frame_count_q;
   assign dct_buffer  = buffer_q;
   assign dct_count   = count_q;

`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
   // Items offered while draining are accepted and discarded; count them.
   logic [15:0] drop_q;
   logic        drop;

   assign drop = (state_q == StDrain) && item_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q <= '0;
      end else if (drop && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   assign dct_drop_count = drop_q;
`endif

endmodule

// File: tb/tb_nios2_oci_dct_sequencer.sv
module tb_nios2_oci_dct_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  item_data = '0;
   logic        item_valid = 1'b0;
   logic        item_ready;
   logic        trace_flush = 1'b0;
   logic        test_ending = 1'b0;
   logic [29:0] frame_data;
   logic [3:0]  frame_count;
   logic        frame_valid;
   logic        frame_ready = 1'b0;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_has_ended;
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
   logic [15:0] dct_drop_count;
`endif

   int errors = 0;
   int checks = 0;

   nios2_oci_dct_sequencer #(.ITEM_W(6), .SLOTS(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .item_data      (item_data),
      .item_valid     (item_valid),
      .item_ready     (item_ready),
      .trace_flush    (trace_flush),
      .test_ending    (test_ending),
      .frame_data     (frame_data),
      .frame_count    (frame_count),
      .frame_valid    (frame_valid),
      .frame_ready    (frame_ready),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
      .dct_drop_count (dct_drop_count),
`endif
      .test_has_ended (test_has_ended)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: mode 0 = filling, 1 = frame pending, 2 = test ended.
   // The buffer is a plain list of items; frames are packed from that list.
   // ---------------------------------------------------------------------------
   int          m_mode = 0;
   int          m_q[$];
   logic [29:0] m_fdata = '0;
   int          m_fcount = 0;
   int          m_drops = 0;
   bit          chk_en = 0;

   function automatic logic [29:0] pack_model();
      logic [29:0] r = '0;
      foreach (m_q[i]) r = r | (30'(m_q[i]) << (6 * i));
      return r;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_mode = 0;
         m_q.delete();
         m_fdata = '0;
         m_fcount = 0;
         m_drops = 0;
      end else begin
         case (m_mode)
            0: begin
               if (item_valid) m_q.push_back(int'(item_data));
               if (m_q.size() == 5 || ((trace_flush || test_ending) && m_q.size() > 0)) begin
                  m_fdata = pack_model();
                  m_fcount = m_q.size();
                  m_q.delete();
                  m_mode = 1;
               end else if (test_ending) begin
                  m_mode = 2;
               end
            end
            1: begin
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
               if (item_valid && m_drops < 65535) m_drops++;
`endif
               if (frame_ready) m_mode = test_ending ? 2 : 0;
            end
            default: ;
         endcase
      end
      chk_en = 1;
   end

   // Single compare process; inputs change at negedge+1 so outputs are settled here.
   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_ready;
         exp_ready = !reset && (m_mode == 0);
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
         exp_ready = !reset && (m_mode == 0 || m_mode == 1);
         chk("drop_count", 32'(dct_drop_count), 32'(m_drops));
`endif
         chk("item_ready", 32'(item_ready), 32'(exp_ready));
         chk("frame_valid", 32'(frame_valid), 32'(m_mode == 1));
         chk("test_has_ended", 32'(test_has_ended), 32'(m_mode == 2));
         chk("dct_count", 32'(dct_count), 32'(m_q.size()));
         chk("dct_buffer", 32'(dct_buffer), 32'(pack_model()));
         if (m_mode == 1) begin
            chk("frame_data", 32'(frame_data), 32'(m_fdata));
            chk("frame_count", 32'(frame_count), 32'(m_fcount));
         end
      end
   end

   // One clock with the given inputs; returns at negedge+1 with outputs settled.
   task automatic cyc(input bit v, input logic [5:0] d, input bit fl, input bit te,
                      input bit fr);
      item_valid  = v;
      item_data   = d;
      trace_flush = fl;
      test_ending = te;
      frame_ready = fr;
      @(negedge clk);
      #1;
   endtask

   logic [29:0] saved;

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (3) cyc(0, 6'd0, 0, 0, 0);
      chk("rst item_ready", 32'(item_ready), 32'd0);
      chk("rst frame_valid", 32'(frame_valid), 32'd0);
      chk("rst frame_data", 32'(frame_data), 32'd0);
      chk("rst frame_count", 32'(frame_count), 32'd0);
      chk("rst dct_buffer", 32'(dct_buffer), 32'd0);
      chk("rst dct_count", 32'(dct_count), 32'd0);
      chk("rst test_has_ended", 32'(test_has_ended), 32'd0);
      reset = 1'b0;
      cyc(0, 6'd0, 0, 0, 0);
      chk("fill item_ready", 32'(item_ready), 32'd1);

      // Full frame, items 1..5
      for (int i = 1; i <= 5; i++) cyc(1, 6'(i), 0, 0, 0);
      chk("full frame_valid", 32'(frame_valid), 32'd1);
      chk("full frame_data", 32'(frame_data), 32'h0510_3081);
      chk("full frame_count", 32'(frame_count), 32'd5);
      chk("full dct_count", 32'(dct_count), 32'd0);
      cyc(0, 6'd0, 0, 0, 1);
      chk("after hs frame_valid", 32'(frame_valid), 32'd0);

      // Partial frame by flush, then flush of an empty buffer
      cyc(1, 6'h3F, 0, 0, 0);
      cyc(1, 6'h2A, 0, 0, 0);
      chk("partial dct_buffer", 32'(dct_buffer), 32'h0000_0ABF);
      cyc(0, 6'd0, 1, 0, 0);
      chk("flush frame_valid", 32'(frame_valid), 32'd1);
      chk("flush frame_data", 32'(frame_data), 32'h0000_0ABF);
      chk("flush frame_count", 32'(frame_count), 32'd2);
      cyc(0, 6'd0, 0, 0, 1);
      cyc(0, 6'd0, 1, 0, 0);
      chk("empty flush frame_valid", 32'(frame_valid), 32'd0);

      // Stalled drain with items offered
      for (int i = 0; i < 5; i++) cyc(1, 6'(i + 11), 0, 0, 0);
      saved = frame_data;
      for (int i = 0; i < 10; i++) begin
         cyc(1, 6'($urandom), 0, 0, 0);
         chk("stall frame_data", 32'(frame_data), 32'(saved));
         chk("stall dct_count", 32'(dct_count), 32'd0);
`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
         if (i == 3) chk("drop_count 4", 32'(dct_drop_count), 32'd4);
`else
         chk("stall item_ready", 32'(item_ready), 32'd0);
`endif
      end
      cyc(0, 6'd0, 0, 0, 1);
      chk("release frame_valid", 32'(frame_valid), 32'd0);
      chk("release item_ready", 32'(item_ready), 32'd1);

      // Reset in the middle of a drain
      for (int i = 0; i < 5; i++) cyc(1, 6'(i + 30), 0, 0, 0);
      chk("pre-reset frame_valid", 32'(frame_valid), 32'd1);
      reset = 1'b1;
      cyc(0, 6'd0, 0, 0, 0);
      chk("mid reset frame_valid", 32'(frame_valid), 32'd0);
      chk("mid reset dct_count", 32'(dct_count), 32'd0);
      reset = 1'b0;
      cyc(0, 6'd0, 0, 0, 0);
      chk("post reset item_ready", 32'(item_ready), 32'd1);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         reset = ($urandom_range(0, 199) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0);
         cyc(($urandom % 3) != 0, 6'($urandom), ($urandom % 8) == 0,
             ($urandom % 150) == 0, ($urandom % 2) == 0);
      end

      // End of test: 3 items, then test_ending
      reset = 1'b1;
      cyc(0, 6'd0, 0, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1, 6'(i + 7), 0, 0, 0);
      cyc(0, 6'd0, 0, 1, 0);
      chk("end frame_valid", 32'(frame_valid), 32'd1);
      chk("end frame_count", 32'(frame_count), 32'd3);
      cyc(0, 6'd0, 0, 1, 1);
      chk("end test_has_ended", 32'(test_has_ended), 32'd1);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 6'($urandom), ($urandom % 2) == 0, 0, 1);
         chk("done sticky", 32'(test_has_ended), 32'd1);
         chk("done item_ready", 32'(item_ready), 32'd0);
         chk("done dct_count", 32'(dct_count), 32'd0);
      end

`ifdef NIOS2_OCI_DCT_OVF_CNT_EN
      // Drop counter saturation
      reset = 1'b1;
      cyc(0, 6'd0, 0, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1, 6'(i), 0, 0, 0);
      for (int i = 0; i < 70000; i++) cyc(1, 6'd1, 0, 0, 0);
      chk("drop_count saturated", 32'(dct_drop_count), 32'h0000_FFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
